motor_mixer: RTL

//  Downstream of the body-frame rate controller. On each completed rate cycle, it latches the

---
 rtl/motor_mixer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/motor_mixer.sv
// rtl/motor_mixer.sv - quad-X motor mixer: latches throttle and rates, mixes over one shared summer, clamps to ESC range
module motor_mixer #(
  parameter int                     RATE_WIDTH       = 16,
  parameter int                     MOTOR_WIDTH      = 8,
  parameter int                     RATE_SHIFT       = 4,
  parameter logic [MOTOR_WIDTH-1:0] MOTOR_MIN        = 8'd0,
  parameter logic [MOTOR_WIDTH-1:0] MOTOR_MAX        = 8'd255,
  parameter logic [MOTOR_WIDTH-1:0] THROTTLE_ARM_MIN = 8'd10
) (
  input  logic                         us_clk,
  input  logic                         resetn,
  input  logic                         start_signal,
  input  logic        [MOTOR_WIDTH-1:0] throttle,
  input  logic signed [RATE_WIDTH-1:0]  yaw_rate,
  input  logic signed [RATE_WIDTH-1:0]  roll_rate,
  input  logic signed [RATE_WIDTH-1:0]  pitch_rate,
  output logic        [MOTOR_WIDTH-1:0] motor_1,
  output logic        [MOTOR_WIDTH-1:0] motor_2,
  output logic        [MOTOR_WIDTH-1:0] motor_3,
  output logic        [MOTOR_WIDTH-1:0] motor_4,
  output logic                         complete_signal,
  output logic                         busy
);

  localparam int SW = RATE_WIDTH + 3;
  localparam logic signed [SW-1:0] MIN_S = $signed({{(SW-MOTOR_WIDTH){1'b0}}, MOTOR_MIN});
  localparam logic signed [SW-1:0] MAX_S = $signed({{(SW-MOTOR_WIDTH){1'b0}}, MOTOR_MAX});

  typedef enum logic [6:0] {
    WAITING = 7'b0000001,
    LATCH   = 7'b0000010,
    CALC1   = 7'b0000100,
    CALC2   = 7'b0001000,
    CALC3   = 7'b0010000,
    CALC4   = 7'b0100000,
    UPDATE  = 7'b1000000
  } state_t;

  state_t state, state_nx;

  logic                         start_prev;
  logic                         start_det;
  logic        [MOTOR_WIDTH-1:0] thr_q;
  logic signed [RATE_WIDTH-1:0]  yaw_q, roll_q, pitch_q;
  logic        [MOTOR_WIDTH-1:0] stage [4];

  logic       calc_en, busy_nx;
  logic [1:0] calc_idx;
  logic       neg_p, neg_r, neg_y;

  logic signed [RATE_WIDTH-1:0] p_sh, r_sh, y_sh;
  logic signed [SW-1:0]         p_ext, r_ext, y_ext, t_ext, sum;
  logic        [MOTOR_WIDTH-1:0] mix_val;

  assign start_det = start_signal & ~start_prev;

  always_comb begin
    state_nx = WAITING;
    calc_en  = 1'b0;
    calc_idx = 2'd0;
    neg_p    = 1'b0;
    neg_r    = 1'b0;
    neg_y    = 1'b0;
    busy_nx  = 1'b1;
    case (state)
      WAITING: begin
        state_nx = start_det ? LATCH : WAITING;
        busy_nx  = 1'b0;
      end
      LATCH:  state_nx = CALC1;
      CALC1: begin
        state_nx = CALC2; calc_en = 1'b1; calc_idx = 2'd0; neg_y = 1'b1;
      end
      CALC2: begin
        state_nx = CALC3; calc_en = 1'b1; calc_idx = 2'd1; neg_r = 1'b1;
      end
      CALC3: begin
        state_nx = CALC4; calc_en = 1'b1; calc_idx = 2'd2;
        neg_p = 1'b1; neg_r = 1'b1; neg_y = 1'b1;
      end
      CALC4: begin
        state_nx = UPDATE; calc_en = 1'b1; calc_idx = 2'd3; neg_p = 1'b1;
      end
      UPDATE: state_nx = WAITING;
      default: begin
        state_nx = WAITING;
        busy_nx  = 1'b0;
      end
    endcase
  end

  // Shared summer: the per-motor sign pattern is the only thing the CALC states change.
  assign p_sh  = pitch_q >>> RATE_SHIFT;
  assign r_sh  = roll_q  >>> RATE_SHIFT;
  assign y_sh  = yaw_q   >>> RATE_SHIFT;
  assign p_ext = SW'(p_sh);
  assign r_ext = SW'(r_sh);
  assign y_ext = SW'(y_sh);
  assign t_ext = $signed({{(SW-MOTOR_WIDTH){1'b0}}, thr_q});
  assign sum   = t_ext + (neg_p ? -p_ext : p_ext) + (neg_r ? -r_ext : r_ext)
               + (neg_y ? -y_ext : y_ext);

  always_comb begin
    mix_val = sum[MOTOR_WIDTH-1:0];
    if (thr_q < THROTTLE_ARM_MIN) mix_val = MOTOR_MIN;
    else if (sum < MIN_S)         mix_val = MOTOR_MIN;
    else if (sum > MAX_S)         mix_val = MOTOR_MAX;
  end

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state           <= WAITING;
      start_prev      <= 1'b0;
      thr_q           <= '0;
      yaw_q           <= '0;
      roll_q          <= '0;
      pitch_q         <= '0;
      for (int i = 0; i < 4; i++) stage[i] <= '0;
      motor_1         <= MOTOR_MIN;
      motor_2         <= MOTOR_MIN;
      motor_3         <= MOTOR_MIN;
      motor_4         <= MOTOR_MIN;
      complete_signal <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= state_nx;
      start_prev      <= start_signal;
      complete_signal <= (state == UPDATE);
      busy            <= busy_nx;
      if (state == LATCH) begin
        thr_q   <= throttle;
        yaw_q   <= yaw_rate;
        roll_q  <= roll_rate;
        pitch_q <= pitch_rate;
      end
      if (calc_en) stage[calc_idx] <= mix_val;
      if (state == UPDATE) begin
        motor_1 <= stage[0];
        motor_2 <= stage[1];
        motor_3 <= stage[2];
        motor_4 <= stage[3];
      end
    end
  end

endmodule
